viterbi_decode: RTL and testbench

Hard-decision Viterbi decoder for the rate-1/2, constraint-length-3 convolutional code produced by the `encode` stage: generators c1 = u^d2 (101) and c2 = u^d1^d2 (111). It sits directly downstream of the encoder and channel. It accepts the serial coded bit stream, with c1 first and then c2 of each pair. It returns the decoded information bits after a fixed traceback latency, using a 4-state add-compare-select unit and register-exchange survivor memory.

---
 rtl/viterbi_decode.sv | 123 ++++++++++++
 tb/tb_viterbi_decode.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_decode.sv
// rtl/viterbi_decode.sv - hard-decision Viterbi decoder for the K=3 rate-1/2 (101,111) code
// Four-state ACS with saturating, normalised metrics and register-exchange survivors.
module viterbi_decode #(
  parameter int TB   = 15,
  parameter int PM_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic code_in,
  input  logic code_vld,
  input  logic frame_start,
  output logic dout,
  output logic dout_vld
);
  localparam int                CNT_W    = $clog2(TB + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(TB);
  localparam logic [PM_W-1:0]   PM_MAX   = '1;

  logic                phase;
  logic                r1;
  logic [PM_W-1:0]     pm       [4];
  logic [TB-1:0]       surv     [4];
  logic [CNT_W-1:0]    step_cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [PM_W-1:0]     acs_pm   [4];
  logic [PM_W-1:0]     norm_pm  [4];
  logic [TB-1:0]       acs_surv [4];
  logic [PM_W-1:0]     min_pm;
  logic [1:0]          best;

  // Hamming distance between the received pair and the label of branch {a,b} --u-->
  function automatic logic [1:0] branch_metric(input logic u, input logic a, input logic b,
                                               input logic rx1, input logic rx2);
    logic c1;
    logic c2;
    c1 = u ^ b;
    c2 = u ^ a ^ b;
    return {1'b0, c1 ^ rx1} + {1'b0, c2 ^ rx2};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] m, input logic [1:0] bm);
    logic [PM_W:0] s;
    s = {1'b0, m} + {{(PM_W-1){1'b0}}, bm};
    return s[PM_W] ? PM_MAX : s[PM_W-1:0];
  endfunction

  for (genvar n = 0; n < 4; n++) begin : g_acs
    localparam logic U  = 1'(n / 2);
    localparam logic A  = 1'(n % 2);
    localparam int   P0 = 2 * (n % 2);
    localparam int   P1 = P0 + 1;

    logic [PM_W-1:0] cand_lo;
    logic [PM_W-1:0] cand_hi;
    logic            take_hi;
    logic [TB-1:0]   pred_surv;

    assign cand_lo   = sat_add(pm[P0], branch_metric(U, A, 1'b0, r1, code_in));
    assign cand_hi   = sat_add(pm[P1], branch_metric(U, A, 1'b1, r1, code_in));
    // strict compare so a tie keeps the {a,0} predecessor
    assign take_hi   = cand_hi < cand_lo;
    assign acs_pm[n] = take_hi ? cand_hi : cand_lo;
    assign pred_surv = take_hi ? surv[P1] : surv[P0];
    assign acs_surv[n] = {pred_surv[TB-2:0], U};
    assign norm_pm[n]  = acs_pm[n] - min_pm;
  end

  always_comb begin
    min_pm = acs_pm[0];
    best   = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (acs_pm[i] < min_pm) begin
        min_pm = acs_pm[i];
        best   = 2'(i);
      end
    end
  end

  assign cnt_next = (step_cnt == CNT_FULL) ? CNT_FULL : step_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= 1'b0;
      r1       <= 1'b0;
      step_cnt <= '0;
      dout     <= 1'b0;
      dout_vld <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pm[i]   <= (i == 0) ? '0 : PM_MAX;
        surv[i] <= '0;
      end
    end else begin
      dout_vld <= 1'b0;
      if (code_vld) begin
        if (frame_start) begin
          // any pending half pair is dropped; this bit is c1 of the new frame
          phase    <= 1'b1;
          r1       <= code_in;
          step_cnt <= '0;
          for (int i = 0; i < 4; i++) begin
            pm[i]   <= (i == 0) ? '0 : PM_MAX;
            surv[i] <= '0;
          end
        end else if (!phase) begin
          phase <= 1'b1;
          r1    <= code_in;
        end else begin
          phase    <= 1'b0;
          step_cnt <= cnt_next;
          for (int i = 0; i < 4; i++) begin
            pm[i]   <= norm_pm[i];
            surv[i] <= acs_surv[i];
          end
          if (cnt_next == CNT_FULL) begin
            dout     <= acs_surv[best][TB-1];
            dout_vld <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_viterbi_decode.sv
// tb/tb_viterbi_decode.sv - randomized bench for viterbi_decode against a path-queue reference model
// Two instances (PM_W=5 and PM_W=3) share one stimulus stream and one model each.
module tb_viterbi_decode;
  localparam int TB = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic code_in, code_vld, frame_start;
  logic dout5, vld5, dout3, vld3;

  always #5 clk = ~clk;

  viterbi_decode #(.TB(TB), .PM_W(5)) dut5 (
    .clk(clk), .rst(rst), .code_in(code_in), .code_vld(code_vld),
    .frame_start(frame_start), .dout(dout5), .dout_vld(vld5));

  viterbi_decode #(.TB(TB), .PM_W(3)) dut3 (
    .clk(clk), .rst(rst), .code_in(code_in), .code_vld(code_vld),
    .frame_start(frame_start), .dout(dout3), .dout_vld(vld3));

  int  total = 0;
  int  bad   = 0;
  bit  checking = 0;
  bit  gaps_on  = 0;
  int  first_pair;

  int  pmmax[2] = '{31, 7};
  int  m_pm[2][4];
  bit  m_phase[2];
  bit  m_r1[2];
  int  m_steps[2];
  bit  m_path[8][$];
  bit  m_tmp[4][$];
  bit  exp_vld[2];
  bit  exp_dout[2];

  bit  info_q[$];
  bit  code_q[$];
  bit  out_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: each state keeps the last TB decisions of its best path as a queue
  task automatic model_init(input int i);
    m_pm[i][0] = 0;
    for (int s = 1; s < 4; s++) m_pm[i][s] = pmmax[i];
    for (int s = 0; s < 4; s++) m_path[4*i+s].delete();
    m_steps[i] = 0;
  endtask

  task automatic model_reset(input int i);
    model_init(i);
    m_phase[i]  = 0;
    m_r1[i]     = 0;
    exp_vld[i]  = 0;
    exp_dout[i] = 0;
  endtask

  task automatic model_step(input int i, input bit rx1, input bit rx2);
    int npm[4];
    int pred[4];
    int cand[2];
    int u, a, p, bm, mn, best;
    for (int n = 0; n < 4; n++) begin
      u = n / 2;
      a = n % 2;
      for (int b = 0; b < 2; b++) begin
        p  = 2 * a + b;
        bm = 0;
        if ((u ^ b) != int'(rx1)) bm++;
        if ((u ^ a ^ b) != int'(rx2)) bm++;
        cand[b] = m_pm[i][p] + bm;
        if (cand[b] > pmmax[i]) cand[b] = pmmax[i];
      end
      if (cand[1] < cand[0]) begin npm[n] = cand[1]; pred[n] = 2 * a + 1; end
      else begin npm[n] = cand[0]; pred[n] = 2 * a; end
    end
    for (int n = 0; n < 4; n++) begin
      m_tmp[n] = m_path[4*i+pred[n]];
      m_tmp[n].push_back(bit'(n / 2));
      if (m_tmp[n].size() > TB) void'(m_tmp[n].pop_front());
    end
    for (int n = 0; n < 4; n++) m_path[4*i+n] = m_tmp[n];
    mn = npm[0];
    for (int n = 1; n < 4; n++) if (npm[n] < mn) mn = npm[n];
    best = -1;
    for (int n = 0; n < 4; n++) begin
      m_pm[i][n] = npm[n] - mn;
      if (best < 0 && m_pm[i][n] == 0) best = n;
    end
    if (m_steps[i] < TB) m_steps[i]++;
    if (m_steps[i] >= TB) begin
      exp_vld[i]  = 1;
      exp_dout[i] = m_path[4*i+best][0];
    end
  endtask

  task automatic model_edge(input bit v, input bit b, input bit fs);
    for (int i = 0; i < 2; i++) begin
      exp_vld[i] = 0;
      if (rst) model_reset(i);
      else if (v) begin
        if (fs) begin
          model_init(i);
          m_r1[i] = b; m_phase[i] = 1;
        end else if (!m_phase[i]) begin
          m_r1[i] = b; m_phase[i] = 1;
        end else begin
          model_step(i, m_r1[i], b);
          m_phase[i] = 0;
        end
      end
    end
  endtask

  task automatic cycle(input bit v, input bit b, input bit fs);
    code_vld = v; code_in = b; frame_start = fs;
    @(posedge clk);
    model_edge(v, b, fs);
    #1;
  endtask

  task automatic send_bit(input bit b, input bit fs);
    int g;
    g = (gaps_on && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    repeat (g) cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    cycle(1'b1, b, fs);
  endtask

  task automatic encode();
    bit d1, d2;
    d1 = 0; d2 = 0;
    code_q.delete();
    foreach (info_q[k]) begin
      code_q.push_back(info_q[k] ^ d2);
      code_q.push_back(info_q[k] ^ d1 ^ d2);
      d2 = d1;
      d1 = info_q[k];
    end
  endtask

  // mode 0: clean, 1: flip c2 of pair fp, 2: one random error per 10 pairs, >=6 apart
  task automatic send_frame(input bit fs, input int mode, input int fp);
    bit err[$];
    int np, p;
    encode();
    np = code_q.size() / 2;
    for (int k = 0; k < 2 * np; k++) err.push_back(1'b0);
    if (mode == 1) err[2*fp+1] = 1'b1;
    if (mode == 2) begin
      for (int j = 0; 10 * j < np; j++) begin
        p = 10 * j + $urandom_range(0, 4);
        if (p < np) err[2*p + $urandom_range(0, 1)] = 1'b1;
      end
    end
    first_pair = -1;
    for (int q = 0; q < np; q++) begin
      send_bit(code_q[2*q] ^ err[2*q], fs && q == 0);
      send_bit(code_q[2*q+1] ^ err[2*q+1], 1'b0);
      if (vld5 === 1'b1 && first_pair < 0) first_pair = q;
    end
  endtask

  task automatic random_info(input int n, input int tail);
    info_q.delete();
    for (int k = 0; k < n; k++) info_q.push_back(1'($urandom_range(0, 1)));
    for (int k = 0; k < tail; k++) info_q.push_back(1'b0);
  endtask

  function automatic int decode_errors(input int n);
    int e;
    e = 0;
    for (int k = 0; k < n; k++)
      if (k >= out_q.size() || out_q[k] != info_q[k]) e++;
    return e;
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      total++;
      if (vld5 !== exp_vld[0] || dout5 !== exp_dout[0]) begin
        bad++;
        $display("FAIL out_pm5 t=%0t: dout=%b vld=%b expected dout=%b vld=%b",
                 $time, dout5, vld5, exp_dout[0], exp_vld[0]);
      end
      total++;
      if (vld3 !== exp_vld[1] || dout3 !== exp_dout[1]) begin
        bad++;
        $display("FAIL out_pm3 t=%0t: dout=%b vld=%b expected dout=%b vld=%b",
                 $time, dout3, vld3, exp_dout[1], exp_vld[1]);
      end
      if (vld5 === 1'b1) out_q.push_back(dout5);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int packed_v;
    code_vld = 0; code_in = 0; frame_start = 0;
    model_reset(0); model_reset(1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    checking = 1;
    check("reset_dout", int'(dout5), 0);
    check("reset_vld", int'(vld5), 0);
    rst = 0;
    cycle(1'b0, 1'b0, 1'b0);

    // encoder model pinned by hand: 1,0,1,1,0... -> 11 01 00 10 10 11 00 00
    info_q = '{1, 0, 1, 1, 0, 0, 0, 0};
    encode();
    packed_v = 0;
    foreach (code_q[k]) packed_v = (packed_v << 1) | int'(code_q[k]);
    check("enc_pairs", packed_v, 16'hD2B0);

    // error-free and single-error frames
    for (int mode = 0; mode < 2; mode++) begin
      info_q = '{1, 0, 1, 1};
      for (int k = 0; k < 16; k++) info_q.push_back(1'b0);
      out_q.delete();
      send_frame(1'b1, mode, 2);
      repeat (2) cycle(1'b0, 1'b0, 1'b0);
      check(mode == 0 ? "clean_first_pair" : "err1_first_pair", first_pair, TB - 1);
      check(mode == 0 ? "clean_count" : "err1_count", out_q.size(), 6);
      packed_v = 0;
      for (int k = 0; k < 6 && k < out_q.size(); k++) packed_v = (packed_v << 1) | int'(out_q[k]);
      check(mode == 0 ? "clean_bits" : "err1_bits", packed_v, 6'b101100);
    end

    // long random stream with sparse errors and gapped code_vld
    gaps_on = 1;
    random_info(2000, TB);
    out_q.delete();
    send_frame(1'b1, 2, 0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    check("rand_count", out_q.size(), 2001);
    check("rand_errors", decode_errors(2001), 0);

    // resynchronisation after a lone c1
    random_info(5, 0);
    send_frame(1'b0, 0, 0);
    send_bit(1'b1, 1'b0);
    random_info(20, TB);
    out_q.delete();
    send_frame(1'b1, 0, 0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    check("resync_first_pair", first_pair, TB - 1);
    check("resync_count", out_q.size(), 21);
    check("resync_errors", decode_errors(21), 0);

    // reset between c1 and c2, with dout last driven to 1
    random_info(20, 0);
    info_q[20-TB] = 1'b1;
    send_frame(1'b1, 0, 0);
    send_bit(1'($urandom_range(0, 1)), 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("pre_reset_dout", int'(dout5), 1);
    rst = 1;
    model_reset(0); model_reset(1);
    #1;
    check("midreset_dout", int'(dout5), 0);
    check("midreset_vld", int'(vld5), 0);
    cycle(1'b0, 1'b0, 1'b0);
    rst = 0;
    random_info(16, TB);
    out_q.delete();
    send_frame(1'b0, 0, 0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    check("postreset_count", out_q.size(), 17);
    check("postreset_errors", decode_errors(17), 0);

    // saturation/tie stress: 40 pairs of 11
    gaps_on = 0;
    out_q.delete();
    for (int q = 0; q < 40; q++) begin
      send_bit(1'b1, q == 0);
      send_bit(1'b1, 1'b0);
    end
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    check("sat_count", out_q.size(), 40 - (TB - 1));

    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
